// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue: streams sequential words from instruction memory into a small FIFO.
// Define FETCHQ_HALT_DETECT_EN to stop fetching after an HLT (opcode 6'h3f) word is queued.
module mips32_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk1,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] start_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_npc,
   output logic        halted
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, RUN, HALT_WAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q;
   logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
   logic            inflight_q;
   logic [31:0]     inflight_addr_q;
   logic [31:0]     fetch_pc_q;
   logic [31:0]     last_instr_q, last_npc_q;
   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     npc_mem   [DEPTH];

   logic push, pop, is_hlt, space;

   // A response arriving in the flush cycle belongs to the abandoned path and is dropped.
   assign push = inflight_q & ~flush;
   assign pop  = if_valid & if_ready;

`ifdef FETCHQ_HALT_DETECT_EN
   assign is_hlt = push & (imem_rdata[31:26] == 6'h3f);
`else
   assign is_hlt = 1'b0;
`endif

   // In-flight reads reserve a slot so a push can never land on a full queue.
   assign space = (count_q + CW'(inflight_q)) < CW'(DEPTH);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = RUN;
      end else begin
         case (state_q)
            IDLE:    if (go) state_d = RUN;
            RUN:     if (is_hlt) state_d = HALT_WAIT;
            default: ;
         endcase
      end
   end

   // The HLT word itself suppresses the request issued alongside its push.
   always_comb begin
      imem_req = 1'b0;
      halted   = 1'b0;
      case (state_q)
         RUN:       imem_req = space & ~flush & ~is_hlt;
`ifdef FETCHQ_HALT_DETECT_EN
         HALT_WAIT: halted = 1'b1;
`endif
         default:   ;
      endcase
   end

   assign imem_addr = fetch_pc_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         count_q         <= '0;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         fetch_pc_q      <= '0;
      end else if (flush) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         inflight_q <= 1'b0;
         fetch_pc_q <= flush_pc;
      end else begin
         if (state_q == IDLE && go) fetch_pc_q <= start_pc;
         else if (imem_req)         fetch_pc_q <= fetch_pc_q + 32'd1;
         inflight_q      <= imem_req;
         inflight_addr_q <= fetch_pc_q;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // NOTE: queue storage has no reset; count_q alone decides which slots are meaningful.
   always_ff @(posedge clk1) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         npc_mem[wr_ptr_q]   <= inflight_addr_q + 32'd1;
      end
   end

   // Registered copy of the visible head so the outputs hold steady once the queue drains.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         last_instr_q <= '0;
         last_npc_q   <= '0;
      end else begin
         last_instr_q <= if_instr;
         last_npc_q   <= if_npc;
      end
   end

   assign if_valid = (count_q != '0);
   assign if_instr = if_valid ? instr_mem[rd_ptr_q] : last_instr_q;
   assign if_npc   = if_valid ? npc_mem[rd_ptr_q]   : last_npc_q;

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed and randomized bench for mips32_fetch_queue against a transaction-level queue model.
// HLT expectations follow FETCHQ_HALT_DETECT_EN.
module tb_mips32_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [31:0] start_pc = '0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_npc;
   logic        halted;

   mips32_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .go         (go),
      .start_pc   (start_pc),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_npc     (if_npc),
      .halted     (halted)
   );

   always #5 clk1 = ~clk1;

   logic [31:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: entries held, one read in flight, and the next addresses expected.
   int          m_entries;
   bit          m_inflight, m_running, m_idle, m_halted;
   logic [31:0] m_infl_addr, exp_req, exp_pc;
   // Memory responder state plus observed DUT activity counters.
   bit          pend;
   logic [31:0] pend_addr;
   int          dut_reqs, dut_pops;
   logic [31:0] last_dut_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'h3f) w[31:26] = 6'h23;
      return w;
   endfunction

   // Called just before a rising edge: compare outputs, then advance the model across the edge.
   task automatic observe();
      bit          pop_m, req_exp, hlt_push;
      logic [31:0] w;
      hlt_push = 1'b0;
`ifdef FETCHQ_HALT_DETECT_EN
      w = mem[m_infl_addr[7:0]];
      hlt_push = m_inflight && !flush && (w[31:26] == 6'h3f);
`else
      w = '0;
`endif
      req_exp = m_running && !flush && (m_entries + int'(m_inflight) < DEPTH) && !hlt_push;
      check("imem_req", {31'd0, imem_req}, {31'd0, req_exp});
      check("if_valid", {31'd0, if_valid}, {31'd0, m_entries > 0});
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      if (req_exp && imem_req) check("imem_addr", imem_addr, exp_req);
      pop_m = (m_entries > 0) && if_ready && !flush;
      if (pop_m) begin
         check("if_instr", if_instr, mem[exp_pc[7:0]]);
         check("if_npc", if_npc, exp_pc + 32'd1);
         exp_pc = exp_pc + 32'd1;
      end
      if (imem_req) begin
         dut_reqs++;
         last_dut_addr = imem_addr;
      end
      if (if_valid && if_ready && !flush) dut_pops++;
      pend      = imem_req;
      pend_addr = imem_addr;
      if (flush) begin
         m_entries  = 0;
         m_inflight = 1'b0;
         m_running  = 1'b1;
         m_idle     = 1'b0;
         m_halted   = 1'b0;
         exp_req    = flush_pc;
         exp_pc     = flush_pc;
      end else begin
         m_entries   = m_entries + int'(m_inflight) - int'(pop_m);
         m_inflight  = req_exp;
         m_infl_addr = exp_req;
         if (req_exp) exp_req = exp_req + 32'd1;
         if (hlt_push) begin
            m_running = 1'b0;
            m_halted  = 1'b1;
         end
         if (go && m_idle) begin
            m_idle    = 1'b0;
            m_running = 1'b1;
            exp_req   = start_pc;
            exp_pc    = start_pc;
         end
      end
   endtask

   // One clock: inputs are set shortly after the falling edge, outputs checked before the rising edge.
   task automatic cycle();
      #2;
      observe();
      @(posedge clk1);
      #1;
      imem_rdata = pend ? mem[pend_addr[7:0]] : 32'hdeadbeef;
      @(negedge clk1);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      check("rst_if_npc", if_npc, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      m_entries = 0;  m_inflight = 1'b0; m_running = 1'b0; m_idle = 1'b1; m_halted = 1'b0;
      exp_req = '0;   exp_pc = '0;       pend = 1'b0;      pend_addr = '0;
      dut_reqs = 0;   dut_pops = 0;      last_dut_addr = '0;
      @(negedge clk1);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int lat, k;
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
      mem[0] = 32'h2801000a;
      mem[1] = 32'h28020014;
      mem[2] = 32'h28030019;

      do_reset();
      repeat (3) cycle();

      // Straight-line program, consumer always ready.
      if_ready = 1'b1;
      start_pc = 32'd0;
      go = 1'b1;
      cycle();
      go = 1'b0;
      lat = 1;
      while (!if_valid && lat < 10) begin
         cycle();
         lat++;
      end
      check("go_to_valid_latency", lat, 32'd3);
      check("first_instr", if_instr, 32'h2801000a);
      check("first_npc", if_npc, 32'd1);
      repeat (6) cycle();

      // Redirect while a pop and a response coincide.
      flush = 1'b1;
      flush_pc = 32'd5;
      cycle();
      flush = 1'b0;
      k = 0;
      while (!if_valid && k < 6) begin
         cycle();
         k++;
      end
      check("flush_target_valid", {31'd0, if_valid}, 32'd1);
      check("flush_target_instr", if_instr, mem[5]);
      check("flush_target_npc", if_npc, 32'd6);
      repeat (4) cycle();

      // Back-pressure: the queue fills and requests stop at DEPTH.
      do_reset();
      if_ready = 1'b0;
      go = 1'b1;
      start_pc = 32'd0;
      cycle();
      go = 1'b0;
      repeat (10) cycle();
      check("full_req_count", dut_reqs, DEPTH);
      check("full_last_addr", last_dut_addr, DEPTH - 1);
      check("full_req_low", {31'd0, imem_req}, 32'd0);
      check("full_valid", {31'd0, if_valid}, 32'd1);
      if_ready = 1'b1;
      k = 0;
      while (!imem_req && k < 5) begin
         cycle();
         k++;
      end
      check("resume_req", {31'd0, imem_req}, 32'd1);
      check("resume_addr", imem_addr, DEPTH);
      repeat (3) cycle();

      // Reset in the middle of operation with three entries queued.
      do_reset();
      if_ready = 1'b0;
      go = 1'b1;
      start_pc = 32'd40;
      cycle();
      go = 1'b0;
      k = 0;
      while (m_entries != 3 && k < 10) begin
         cycle();
         k++;
      end
      check("pre_reset_entries", m_entries, 32'd3);
      do_reset();
      repeat (6) cycle();
      check("post_reset_reqs", dut_reqs, 32'd0);

      // HLT word at address 8.
      mem[8] = 32'hfc000000;
      do_reset();
      if_ready = 1'b1;
      go = 1'b1;
      start_pc = 32'd0;
      cycle();
      go = 1'b0;
      repeat (20) cycle();
`ifdef FETCHQ_HALT_DETECT_EN
      check("hlt_last_addr", last_dut_addr, 32'd8);
      check("hlt_halted", {31'd0, halted}, 32'd1);
      check("hlt_delivered", dut_pops, 32'd9);
      check("hlt_drained", {31'd0, if_valid}, 32'd0);
`else
      check("hlt_halted_off", {31'd0, halted}, 32'd0);
      check("hlt_fetch_continues", {31'd0, dut_reqs > 9}, 32'd1);
`endif
      mem[8] = rand_word();

      // Redirect near the top of the address space to cover wrap-around.
      flush = 1'b1;
      flush_pc = 32'hfffffffc;
      cycle();
      flush = 1'b0;
      repeat (10) cycle();
      check("wrap_exp_pc_moved", {31'd0, exp_pc < 32'h10}, 32'd1);

      // Random consumer stalls, redirects and stray go pulses.
      for (int i = 0; i < 300; i++) begin
         if_ready = ($urandom_range(0, 3) != 0);
         go       = ($urandom_range(0, 15) == 0);
         start_pc = $urandom;
         flush    = ($urandom_range(0, 19) == 0);
         flush_pc = $urandom;
         cycle();
      end
      go = 1'b0;
      flush = 1'b0;
      repeat (8) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries buffered; legal values 2, 4, 8.
REQ-002 clk1  input  1  single clock; all state updates on posedge clk1.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 go  input  1  one-cycle pulse; starts fetching at start_pc.
REQ-005 start_pc  input  32  word address of the first instruction.
REQ-006 flush  input  1  taken-branch redirect from the pipeline.
REQ-007 flush_pc  input  32  word address of the redirect target.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  word address of the read.
REQ-010 imem_rdata  input  32  read data, valid exactly 1 cycle after imem_req.
REQ-011 if_valid  output  1  head entry is valid for the IF stage.
REQ-012 if_ready  input  1  IF stage accepts the head entry.
REQ-013 if_instr  output  32  head instruction word.
REQ-014 if_npc  output  32  head instruction address + 1.
REQ-015 halted  output  1  fetching is stopped after an HLT.

Function
REQ-016 The states SHALL be IDLE, RUN and HALT_WAIT; reset enters IDLE.
REQ-017 IDLE -> RUN on go; the fetch PC loads start_pc and the first imem_req asserts in the next cycle.
REQ-018 In RUN, imem_req SHALL assert whenever (stored entries + in-flight reads) < DEPTH, with imem_addr = fetch PC; the fetch PC then increments by 1 and wraps modulo 2^32.
REQ-019 The response SHALL be written into the queue on the cycle after its request, tagged with npc = request address + 1.
REQ-020 A pop SHALL occur when if_valid and if_ready are both high; the outputs then advance to the next entry in the same cycle.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged; a push into a full queue SHALL never occur, because REQ-018 prevents it.
REQ-022 if_valid SHALL be 0 whenever the count is 0; if_instr and if_npc SHALL hold their last value while invalid.
REQ-023 flush SHALL have priority over go, push and pop: the queue empties, any in-flight response is discarded, the fetch PC loads flush_pc, the state becomes RUN (also from IDLE and HALT_WAIT), and halted clears.
REQ-024 When a response with opcode imem_rdata[31:26] = 6'h3f (HLT) is pushed, the block SHALL enter HALT_WAIT and issue no further requests; halted asserts the following cycle, and entries already queued still drain.
REQ-025 go SHALL be ignored outside IDLE.
REQ-026 The end-to-end latency from go to the first if_valid SHALL be 3 cycles.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear the count, pointers, in-flight tag and fetch PC to 0, and set the state to IDLE.
REQ-028 During reset, imem_req, imem_addr, if_valid, if_instr, if_npc and halted SHALL all be 0.
REQ-029 Reset asserted mid-operation SHALL discard all entries and in-flight reads; no response SHALL be pushed after rst_n is released.

Configuration
REQ-030 Macro FETCHQ_HALT_DETECT_EN: when defined, REQ-024 applies.
REQ-031 When FETCHQ_HALT_DETECT_EN is undefined, HALT_WAIT is never entered, HLT words are queued like any other instruction, and halted is tied to 0.

Verification
REQ-032 Reset, then go with start_pc=0, Mem[0..2] = 2801000a, 28020014, 28030019, if_ready=1 -> if_instr stream is 2801000a, 28020014, 28030019 with if_npc 1, 2, 3; first if_valid 3 cycles after go.
REQ-033 DEPTH=4, if_ready=0 for 10 cycles after go -> exactly 4 requests issued (addresses 0..3), count=4, imem_req low; then if_ready=1 -> requests resume at address 4.
REQ-034 Mem[8]=fc000000, go at 0, if_ready=1 (FETCHQ_HALT_DETECT_EN defined) -> last request at address 8, halted=1, entries 0..8 are delivered, and none at 9.
REQ-035 flush with flush_pc=5 on the same cycle as a pop and an in-flight response -> next if_instr=Mem[5], if_npc=6; the discarded response never appears.
REQ-036 rst_n low for 1 cycle while count=3 -> all outputs 0 and state IDLE; no requests until the next go.
